// File: rtl/fpu_div.sv
// fp16 division coprocessor: special-operand decode, sequential radix-2
// restoring significand divider, then normalise and round-to-nearest-even.
module fpu_div #(
    parameter int FRACW   = 10,
    parameter int EXPW    = 5,
    parameter int BIAS    = 15,
    parameter int EXP_MAX = (1 << EXPW) - 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [EXPW+FRACW:0]   fpuIn1,
    input  logic [EXPW+FRACW:0]   fpuIn2,
    output logic [EXPW+FRACW:0]   fpuOut,
    output logic                  done,
    output logic                  busy,
    output logic [3:0]            condCodes,
    output logic [4:0]            opStatusFlags
);
    localparam int W  = 1 + EXPW + FRACW;
    localparam int QW = FRACW + 3;           // quotient bits
    localparam int RW = FRACW + 2;           // partial remainder bits
    localparam int EW = EXPW + 2;            // signed working exponent
    localparam int CW = $clog2(FRACW + 3);

    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic signed [EW-1:0] EMAX_S = EW'(EXP_MAX);
    localparam logic [CW-1:0]        ITER_LAST = CW'(FRACW + 2);
    localparam logic [W-1:0]         QNAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    function automatic logic [W-1:0] inf_word(input logic s);
        return {s, {EXPW{1'b1}}, {FRACW{1'b0}}};
    endfunction

    function automatic logic [W-1:0] zero_word(input logic s);
        return {s, {(W-1){1'b0}}};
    endfunction

    // {Z, C, N, V}
    function automatic logic [3:0] cc_of(input logic [W-1:0] word);
        return {(word[W-2:0] == '0), 1'b0, word[W-1], 1'b0};
    endfunction

    // RNE on the normalised quotient, then overflow/underflow saturation.
    // Returns {flags, word}.
    function automatic logic [W+4:0] round_pack(
        input logic                   s,
        input logic signed [EW-1:0]   e,
        input logic [FRACW-1:0]       frac,
        input logic                   guard,
        input logic                   sticky
    );
        logic                  inc;
        logic [FRACW:0]        fr;
        logic signed [EW-1:0]  er;
        logic [4:0]            fl;
        logic [W-1:0]          word;
        inc = guard & (sticky | frac[0]);
        fr  = {1'b0, frac} + {{FRACW{1'b0}}, inc};
        er  = fr[FRACW] ? e + ONE_S : e;
        fl  = {4'b0000, guard | sticky};
        if (er >= EMAX_S) begin
            word = inf_word(s);
            fl   = 5'b00101;
        end else if (er <= ZERO_S) begin
            word = zero_word(s);
            fl   = 5'b00011;
        end else begin
            word = {s, er[EXPW-1:0], fr[FRACW-1:0]};
        end
        return {fl, word};
    endfunction

    state_t                state_q, state_d;
    logic [W-1:0]          out_q, out_d;
    logic [4:0]            flags_q, flags_d;
    logic [3:0]            cc_q, cc_d;
    logic                  sign_q, sign_d;
    logic signed [EW-1:0]  eb_q, eb_d;
    logic [FRACW:0]        div_q, div_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [QW-1:0]         quo_q, quo_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  s1, s2;
    logic [EXPW-1:0]       e1, e2;
    logic [FRACW-1:0]      f1, f2;
    logic                  zero1, zero2, eall1, eall2, inf1, inf2, nan1, nan2;
    logic                  special_in;
    logic signed [EW-1:0]  eb_in;
    logic [W-1:0]          spec_word;
    logic [4:0]            spec_flags;

    logic                  q_bit;
    logic [RW-1:0]         rem_sub;
    logic                  norm_hi;
    logic [FRACW-1:0]      rnd_frac;
    logic                  rnd_guard, rnd_sticky;
    logic signed [EW-1:0]  rnd_exp;
    logic [W+4:0]          rnd_res;

    // Operand decode; subnormals (exponent 0) are treated as signed zero.
    assign {s1, e1, f1} = fpuIn1;
    assign {s2, e2, f2} = fpuIn2;
    assign zero1 = (e1 == '0);
    assign zero2 = (e2 == '0);
    assign eall1 = (e1 == {EXPW{1'b1}});
    assign eall2 = (e2 == {EXPW{1'b1}});
    assign inf1  = eall1 && (f1 == '0);
    assign inf2  = eall2 && (f2 == '0);
    assign nan1  = eall1 && (f1 != '0);
    assign nan2  = eall2 && (f2 != '0);
    assign special_in = zero1 | zero2 | eall1 | eall2;
    assign eb_in = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS_S;

    // Special-operand result, evaluated in priority order.
    always_comb begin
        spec_word  = zero_word(s1 ^ s2);
        spec_flags = 5'b00000;
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
            spec_word  = QNAN;
            spec_flags = 5'b10000;
        end else if (inf1) begin
            spec_word  = inf_word(s1 ^ s2);
        end else if (inf2) begin
            spec_word  = zero_word(s1 ^ s2);
        end else if (zero2) begin
            spec_word  = inf_word(s1 ^ s2);
            spec_flags = 5'b01000;
        end
    end

    // One restoring step: subtract when the remainder covers the divisor.
    assign q_bit   = (rem_q >= {1'b0, div_q});
    assign rem_sub = q_bit ? rem_q - {1'b0, div_q} : rem_q;

    // Normalise: quotient lies in [0.5, 2), leading one at bit QW-1 or QW-2.
    assign norm_hi    = quo_q[QW-1];
    assign rnd_frac   = norm_hi ? quo_q[QW-2:2] : quo_q[QW-3:1];
    assign rnd_guard  = norm_hi ? quo_q[1] : quo_q[0];
    assign rnd_sticky = (norm_hi & quo_q[0]) | (rem_q != '0);
    assign rnd_exp    = norm_hi ? eb_q : eb_q - ONE_S;
    assign rnd_res    = round_pack(sign_q, rnd_exp, rnd_frac, rnd_guard, rnd_sticky);

    // Next-state and datapath updates for the IDLE/DIVIDE/ROUND/DONE sequence.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        flags_d = flags_q;
        cc_d    = cc_q;
        sign_d  = sign_q;
        eb_d    = eb_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sign_d  = s1 ^ s2;
                    eb_d    = eb_in;
                    div_d   = {1'b1, f2};
                    rem_d   = {2'b01, f1};
                    quo_d   = '0;
                    cnt_d   = ITER_LAST;
                    flags_d = 5'b00000;
                    cc_d    = 4'b0000;
                    if (special_in) begin
                        out_d   = spec_word;
                        flags_d = spec_flags;
                        cc_d    = cc_of(spec_word);
                        state_d = DONE;
                    end else begin
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[QW-2:0], q_bit};
                if (cnt_q == '0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ROUND: begin
                out_d   = rnd_res[W-1:0];
                flags_d = rnd_res[W+4:W];
                cc_d    = cc_of(rnd_res[W-1:0]);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and architected outputs; reset aborts any operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            flags_q <= '0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            cc_q    <= cc_d;
        end
    end

    // Divider datapath registers; always reloaded when an operation starts.
    always_ff @(posedge clock) begin
        sign_q <= sign_d;
        eb_q   <= eb_d;
        div_q  <= div_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        cnt_q  <= cnt_d;
    end

    assign fpuOut        = out_q;
    assign opStatusFlags = flags_q;
    assign condCodes     = cc_q;
    assign done          = (state_q == DONE);
    assign busy          = (state_q == DIVIDE) || (state_q == ROUND);
endmodule

// File: tb/tb_fpu_div.sv
// Bench for fpu_div: directed cases plus randomized operands checked against
// an exact-arithmetic reference of fp16 division with RNE and flush-to-zero.
module tb_fpu_div;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] fpuIn1, fpuIn2;
    logic [15:0] fpuOut;
    logic        done, busy;
    logic [3:0]  condCodes;
    logic [4:0]  opStatusFlags;

    int errors = 0;
    int checks = 0;

    fpu_div dut (
        .clock(clock), .reset(reset), .start(start),
        .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuOut(fpuOut),
        .done(done), .busy(busy), .condCodes(condCodes),
        .opStatusFlags(opStatusFlags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: classify operands, else divide the significands exactly and
    // round the true quotient to nearest-even using the exact remainder.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] o, output logic [4:0] fl,
                                  output logic [3:0] cc, output bit spec);
        int e1, e2, ex;
        longint na, nb, m, r;
        bit s, z1, z2, i1, i2, n1, n2, inc;
        s  = a[15] ^ b[15];
        e1 = int'(a[14:10]);
        e2 = int'(b[14:10]);
        z1 = (e1 == 0);
        z2 = (e2 == 0);
        i1 = (e1 == 31) && (a[9:0] == 0);
        i2 = (e2 == 31) && (b[9:0] == 0);
        n1 = (e1 == 31) && (a[9:0] != 0);
        n2 = (e2 == 31) && (b[9:0] != 0);
        spec = z1 || z2 || (e1 == 31) || (e2 == 31);
        fl = 5'b00000;
        o  = {s, 15'h0000};
        if (n1 || n2 || (z1 && z2) || (i1 && i2)) begin
            o = 16'h7E00; fl = 5'b10000;
        end else if (i1) begin
            o = {s, 5'h1F, 10'h000};
        end else if (i2) begin
            o = {s, 15'h0000};
        end else if (z2) begin
            o = {s, 5'h1F, 10'h000}; fl = 5'b01000;
        end else if (z1) begin
            o = {s, 15'h0000};
        end else begin
            na = 1024 + longint'(a[9:0]);
            nb = 1024 + longint'(b[9:0]);
            ex = e1 - e2 + 15;
            if (na >= nb) begin
                m = (na * 1024) / nb; r = (na * 1024) % nb;
            end else begin
                m = (na * 2048) / nb; r = (na * 2048) % nb; ex = ex - 1;
            end
            inc = (2 * r > nb) || ((2 * r == nb) && (m % 2 == 1));
            if (inc) m = m + 1;
            if (m == 2048) begin m = 1024; ex = ex + 1; end
            if (r != 0) fl[0] = 1'b1;
            if (ex >= 31) begin
                o = {s, 5'h1F, 10'h000}; fl = 5'b00101;
            end else if (ex <= 0) begin
                o = {s, 15'h0000}; fl = 5'b00011;
            end else begin
                o = {s, 5'(ex), 10'(m)};
            end
        end
        cc = {(o[14:0] == 15'h0000), 1'b0, o[15], 1'b0};
    endfunction

    // Issue one operation, follow it to completion and compare everything.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [15:0] eo;
        logic [4:0]  ef;
        logic [3:0]  ec;
        bit          sp, busy_ok;
        int          n;
        model(a, b, eo, ef, ec, sp);
        @(negedge clock);
        fpuIn1 = a; fpuIn2 = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        if (!sp) check({tag, "_flags_cleared"}, 32'(opStatusFlags), 32'h0);
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clock);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'h1);
        check({tag, "_latency"}, 32'(n), sp ? 32'd1 : 32'd15);
        if (!sp) check({tag, "_busy_during"}, 32'(busy_ok), 32'h1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'h0);
        check({tag, "_out"}, 32'(fpuOut), 32'(eo));
        check({tag, "_flags"}, 32'(opStatusFlags), 32'(ef));
        check({tag, "_cc"}, 32'(condCodes), 32'(ec));
    endtask

    function automatic logic [15:0] rand_operand();
        logic [15:0] v;
        int          cls;
        v   = 16'($urandom);
        cls = $urandom_range(0, 11);
        if (cls == 0) v[14:10] = 5'h00;
        else if (cls == 1) v[14:10] = 5'h1F;
        else if (cls == 2) v[9:0] = 10'h000;
        return v;
    endfunction

    initial begin
        int n;
        logic [15:0] held;
        reset = 1'b1; start = 1'b0; fpuIn1 = '0; fpuIn2 = '0;
        repeat (3) @(negedge clock);
        check("rst_out", 32'(fpuOut), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cc", 32'(condCodes), 32'h0);
        check("rst_flags", 32'(opStatusFlags), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_hold_done", 32'(done), 32'h0);

        run_op(16'h3C00, 16'h4000, "half");
        check("half_exact", 32'(fpuOut), 32'h3800);
        run_op(16'h3C00, 16'h4200, "third");
        check("third_exact", 32'(fpuOut), 32'h3555);
        check("third_inexact", 32'(opStatusFlags), 32'h01);
        run_op(16'hC500, 16'h4000, "neg5_2");
        check("neg5_2_exact", 32'(fpuOut), 32'hC100);
        run_op(16'h3C00, 16'h0000, "divzero");
        check("divzero_exact", 32'(fpuOut), 32'h7C00);
        run_op(16'h0000, 16'h0000, "zero_zero");
        check("zero_zero_exact", 32'(fpuOut), 32'h7E00);
        run_op(16'h0000, 16'h4000, "zero_num");
        check("zero_num_z", 32'(condCodes), 32'h8);
        run_op(16'h7BFF, 16'h1400, "ovf");
        check("ovf_flags", 32'(opStatusFlags), 32'h05);
        run_op(16'h0400, 16'h7800, "unf");
        check("unf_flags", 32'(opStatusFlags), 32'h03);
        run_op(16'h7C00, 16'h7C00, "inf_inf");
        run_op(16'hFC00, 16'h4000, "inf_num");
        run_op(16'h4000, 16'hFC00, "num_inf");
        run_op(16'h7C01, 16'h3C00, "nan_in");
        run_op(16'h0201, 16'h3C00, "subnorm");

        // DONE holds its result while start stays low.
        held = fpuOut;
        repeat (4) @(negedge clock);
        check("done_hold_out", 32'(fpuOut), 32'(held));
        check("done_hold_done", 32'(done), 32'h1);

        // A start pulse during DIVIDE must not disturb the running 1/2.
        @(negedge clock);
        fpuIn1 = 16'h3C00; fpuIn2 = 16'h4000; start = 1'b1;
        @(negedge clock);
        start = 1'b0; n = 1;
        repeat (3) begin @(negedge clock); n++; end
        fpuIn1 = 16'h4200; fpuIn2 = 16'h3C00; start = 1'b1;
        @(negedge clock); n++;
        start = 1'b0;
        while (!done && n < 40) begin @(negedge clock); n++; end
        check("ignore_latency", 32'(n), 32'd15);
        check("ignore_out", 32'(fpuOut), 32'h3800);
        // Back-to-back from DONE.
        run_op(16'h3C00, 16'h4200, "b2b_third");

        // Reset during DIVIDE aborts the operation.
        @(negedge clock);
        fpuIn1 = 16'h3C00; fpuIn2 = 16'h4200; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        check("pre_abort_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_out", 32'(fpuOut), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_flags", 32'(opStatusFlags), 32'h0);
        check("abort_cc", 32'(condCodes), 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_no_result", 32'(done), 32'h0);
        run_op(16'h4000, 16'h3C00, "after_abort");
        check("after_abort_exact", 32'(fpuOut), 32'h4000);

        for (int i = 0; i < 150; i++) begin
            run_op(rand_operand(), rand_operand(), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
